multiport_regfile: RTL

Parametrised integer register file for the RV32IM pipeline, replacing the single-write, two-read file. Provides NRP registered read ports, NWP write ports with write-first bypass, hardwired x0, and a pending-write scoreboard for hazard detection. Registers are zeroed by a sequential clear sweep after reset. Sits between decode (reads, issue) and writeback (writes).

---
 rtl/rf_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 48 ++++
 rtl/multiport_regfile.sv | 105 ++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared types and helpers for the multiport integer register file.
// Holds the clear/run state type, the x0 index and the address-width helper.
package rf_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_X0 = 0;

  // Smallest width able to address n registers (n >= 2 gives at least 1).
  function automatic int rf_addr_width(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
// RD_BUSY is a plain lookup of the pending vector (no same-cycle bypass).
module regfile_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  parameter int NWP   = 2,
  parameter int AW    = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              run,
  input  logic              issue_en,
  input  logic [AW-1:0]     issue_rd,
  input  logic              flush,
  input  logic [NWP-1:0]    wr_en,
  input  logic [NWP*AW-1:0] wr_addr,
  input  logic [NRP*AW-1:0] rd_addr,
  output logic [NRP-1:0]    rd_busy
);

  logic [NREGS-1:0] pending_reg;
  logic [NREGS-1:0] pending_next;

  // Priority, lowest to highest: writeback clear, issue set, flush.
  always_comb begin
    pending_next = pending_reg;
    if (run) begin
      for (int w = 0; w < NWP; w++) begin
        if (wr_en[w]) pending_next[wr_addr[w*AW +: AW]] = 1'b0;
      end
      if (issue_en) pending_next[issue_rd] = 1'b1;
      if (flush) pending_next = '0;
    end
    pending_next[RF_X0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) pending_reg <= '0;
    else       pending_reg <= pending_next;
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_busy
    assign rd_busy[gi] = run & pending_reg[rd_addr[gi*AW +: AW]];
  end

endmodule

// File: rtl/multiport_regfile.sv
// RV32IM integer register file: NRP registered read ports, NWP write ports with
// write-first bypass, hardwired x0, post-reset clear sweep and hazard scoreboard.
module multiport_regfile
  import rf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRP    = 2,
  parameter int NWP    = 2,
  localparam int AW    = rf_addr_width(NREGS)
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [NRP*AW-1:0]    RD_ADDR,
  output logic [NRP*XLEN-1:0]  RD_DATA,
  output logic [NRP-1:0]       RD_BUSY,
  input  logic [NWP-1:0]       WR_EN,
  input  logic [NWP*AW-1:0]    WR_ADDR,
  input  logic [NWP*XLEN-1:0]  WR_DATA,
  input  logic                 ISSUE_EN,
  input  logic [AW-1:0]        ISSUE_RD,
  input  logic                 FLUSH,
  output logic                 READY
);

  rf_state_e       state_reg;
  logic [AW-1:0]   cnt_reg;
  logic            ready_reg;
  logic            run;
  logic [XLEN-1:0] mem [NREGS];

  assign run   = (state_reg == RF_RUN);
  assign READY = ready_reg;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg <= RF_CLEAR;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else if (state_reg == RF_CLEAR) begin
      cnt_reg <= cnt_reg + 1'b1;
      if (cnt_reg == AW'(NREGS - 1)) begin
        state_reg <= RF_RUN;
        ready_reg <= 1'b1;
      end
    end
  end

  // Later ports are assigned last, so port 1 wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (!run) begin
        mem[cnt_reg] <= '0;
      end else begin
        for (int w = 0; w < NWP; w++) begin
          if (WR_EN[w] && (WR_ADDR[w*AW +: AW] != AW'(RF_X0)))
            mem[WR_ADDR[w*AW +: AW]] <= WR_DATA[w*XLEN +: XLEN];
        end
      end
    end
  end

  for (genvar gi = 0; gi < NRP; gi++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rd_next;
    logic [XLEN-1:0] rd_data_reg;

    assign addr = RD_ADDR[gi*AW +: AW];

    always_comb begin
      rd_next = mem[addr];
      for (int w = 0; w < NWP; w++) begin
        if (WR_EN[w] && (WR_ADDR[w*AW +: AW] == addr))
          rd_next = WR_DATA[w*XLEN +: XLEN];
      end
      if (!run || (addr == AW'(RF_X0))) rd_next = '0;
    end

    always_ff @(posedge CLK) begin
      if (RESET) rd_data_reg <= '0;
      else       rd_data_reg <= rd_next;
    end

    assign RD_DATA[gi*XLEN +: XLEN] = rd_data_reg;
  end

  regfile_scoreboard #(
    .NREGS (NREGS),
    .NRP   (NRP),
    .NWP   (NWP),
    .AW    (AW)
  ) u_scoreboard (
    .CLK      (CLK),
    .RESET    (RESET),
    .run      (run),
    .issue_en (ISSUE_EN),
    .issue_rd (ISSUE_RD),
    .flush    (FLUSH),
    .wr_en    (WR_EN),
    .wr_addr  (WR_ADDR),
    .rd_addr  (RD_ADDR),
    .rd_busy  (RD_BUSY)
  );

endmodule
